ws2812_pixel_serializer: RTL
============================

// Module: ws2812_pixel_serializer
// PURPOSE
//  Downstream of the Game-of-Life controller. Turns the controller's load_sreg/transmit_pixel/pixel_value
//  strobes into the single-wire WS2812B waveform. Each pixel is 24 GRB bits, MSB first, 15 clk/bit (12 MHz).
//  Alive/dead cells map to fixed parameterised colours with optional brightness scaling.
// PARAMETERS
//  CYCLES_PER_BIT  15         clocks per WS2812 bit slot (1.25 us @ 12 MHz)
//  T0H_CYCLES      4          high time for a '0' bit
//  T1H_CYCLES      10         high time for a '1' bit
//  ALIVE_GRB       24'h200000 colour loaded when pixel_value=1 (G,R,B bytes)
//  DEAD_GRB        24'h000000 colour loaded when pixel_value=0
//  BRIGHT_SHIFT    0          right shift applied to each 8-bit channel at load (0..7)
// PORTS
//  clk             in   1   system clock
//  rst             in   1   asynchronous, active-high reset
//  load_sreg       in   1   1-cycle strobe: latch colour for pixel_value into shift register
//  transmit_pixel  in   1   held high for exactly 24*CYCLES_PER_BIT clocks while the pixel is sent
//  pixel_value     in   1   cell state sampled on load_sreg
//  ws_out          out  1   registered WS2812B data line
//  busy            out  1   high while in SEND
//  bit_index       out  5   index of bit being sent (0 = MSB/G[7] .. 23 = B[0])
//  proto_err       out  1   sticky protocol-error flag, cleared only by rst
// BEHAVIOUR
//  - Reset (async): state=IDLE, sreg=0, bit/cycle counters=0, ws_out=0, busy=0, bit_index=0, proto_err=0.
//  - States: IDLE -> (load_sreg) LOADED -> (transmit_pixel) SEND -> (24th bit slot ends) DONE -> (!transmit_pixel) IDLE.
//  - Load: on load_sreg, sreg <= per-channel (colour_byte >> BRIGHT_SHIFT), colour = pixel_value ? ALIVE_GRB : DEAD_GRB.
//  - SEND: cyc counts 0..CYCLES_PER_BIT-1; ws_out next = (cyc < (sreg[23] ? T1H_CYCLES : T0H_CYCLES)).
//    At cyc=CYCLES_PER_BIT-1: cyc<=0, sreg<<=1, bit_index+=1. After bit 23 slot ends -> DONE, busy=0.
//  - Latency: ws_out rises 1 clk after the first cycle transmit_pixel is seen high in LOADED; the total high+low
//    footprint is exactly 360 clks per pixel with defaults.
//  - DONE/IDLE: ws_out=0. transmit_pixel still high in DONE is legal (controller's inclusive count); no extra bits sent.
//  - Errors (each sets proto_err, never clears without rst):
//    * transmit_pixel falls in SEND before bit 23 ends -> abort to IDLE, ws_out=0 next clk.
//    * transmit_pixel high in IDLE (no prior load) -> stay IDLE, ws_out=0.
//    * load_sreg during SEND -> ignored, current pixel completes unchanged.
//  - load_sreg in LOADED or DONE: re-latch colour (latest wins), no error. Simultaneous load_sreg+transmit_pixel
//    in IDLE: latch colour, go LOADED, transmit starts next cycle -> proto_err NOT set.
//  - Long low between frames (reset/latch >=50 us) is the controller's IDLE's job; this block only holds ws_out=0.
//  - Reset mid-SEND: ws_out drops to 0 asynchronously; the pixel is lost.
// STRUCTURE
//  - Shared package ws2812_pkg: state enum (IDLE, LOADED, SEND, DONE), CYCLES_PER_BIT, T0H/T1H defaults,
//    BITS_PER_PIXEL=24; controller's TRANSMIT_CYCLES is derived from the same constants.
//  - One sub-module: ws2812_bit_timer (cyc counter + high/low compare, outputs slot_end and level).
//  - Parent holds FSM, 24-bit shift register, colour/brightness mux, and the error flag.
// TESTING
//  1. pixel_value=1, load, transmit 360 clks (defaults): ws_out high 4,4,10,4,4,4,4,4 then 16x4-clk pulses; proto_err=0.
//  2. BRIGHT_SHIFT=2, ALIVE_GRB=24'hFF8040: loaded sreg = 24'h3F2010; check pulse widths per bit.
//  3. Drop transmit_pixel at clk 100 of SEND -> ws_out=0 next clk, state IDLE, proto_err=1.
//  4. transmit_pixel without load_sreg -> ws_out stays 0 for all 360 clks, proto_err=1.
//  5. 64 back-to-back pixels via controller model (load, then 360-clk transmit, with a 2-clk gap) -> 64*24 correct bits.
//  6. Assert rst at bit 12 -> ws_out=0 within the same cycle, all outputs at reset values, next pixel sends cleanly.

Source files
------------

// File: rtl/ws2812_pkg.sv
// -----------------------------------------------------------------------------
// ws2812_pkg
// Shared constants and types for the WS2812B pixel path. The Game-of-Life
// controller derives its transmit window (TRANSMIT_CYCLES) from the same
// numbers, so the serializer and the controller cannot drift apart.
//   state_t          serializer FSM states
//   CYCLES_PER_BIT   clocks per WS2812 bit slot (1.25 us at 12 MHz)
//   T0H/T1H_CYCLES   high time of a '0' / '1' bit
//   BITS_PER_PIXEL   GRB bits per pixel, MSB first
//   scale_grb()      per-channel brightness shift of a packed GRB word
// -----------------------------------------------------------------------------
package ws2812_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      SEND   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int CYCLES_PER_BIT  = 15;
   localparam int T0H_CYCLES      = 4;
   localparam int T1H_CYCLES      = 10;
   localparam int BITS_PER_PIXEL  = 24;
   localparam int BIT_IDX_W       = 5;
   localparam int TRANSMIT_CYCLES = BITS_PER_PIXEL * CYCLES_PER_BIT;

   localparam logic [23:0] ALIVE_GRB_DEFAULT = 24'h200000;
   localparam logic [23:0] DEAD_GRB_DEFAULT  = 24'h000000;

   // Each byte is shifted on its own so no bits bleed between channels.
   function automatic logic [23:0] scale_grb(input logic [23:0] grb, input int shift);
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
      g = grb[23:16] >> shift;
      r = grb[15:8]  >> shift;
      b = grb[7:0]   >> shift;
      return {g, r, b};
   endfunction

endpackage

// File: rtl/ws2812_pixel_serializer_if.sv
// -----------------------------------------------------------------------------
// ws2812_pixel_serializer_if
// Strobe/status bundle between the Game-of-Life controller (master) and the
// WS2812B serializer (slave).
//   load_sreg       controller -> serializer  latch colour for pixel_value
//   transmit_pixel  controller -> serializer  high for the whole pixel window
//   pixel_value     controller -> serializer  cell state (1 = alive)
//   ws_out          serializer -> line        WS2812B data line
//   busy            serializer -> controller  high while bits are going out
//   bit_index       serializer -> controller  bit currently sent (0 = G[7])
//   proto_err       serializer -> controller  sticky protocol error
// -----------------------------------------------------------------------------
interface ws2812_pixel_serializer_if;
   import ws2812_pkg::*;

   logic                 load_sreg;
   logic                 transmit_pixel;
   logic                 pixel_value;
   logic                 ws_out;
   logic                 busy;
   logic [BIT_IDX_W-1:0] bit_index;
   logic                 proto_err;

   modport master (
      output load_sreg, transmit_pixel, pixel_value,
      input  ws_out, busy, bit_index, proto_err
   );

   modport slave (
      input  load_sreg, transmit_pixel, pixel_value,
      output ws_out, busy, bit_index, proto_err
   );

endinterface

// File: rtl/ws2812_bit_timer.sv
// -----------------------------------------------------------------------------
// ws2812_bit_timer
// Cycle counter for one WS2812 bit slot plus the high/low compare.
//   clk, rst     clock, asynchronous active-high reset
//   i_run        count while high, hold at 0 while low
//   i_one        value of the bit in the current slot
//   o_slot_end   last cycle of the current slot
//   o_level      line level this cycle of the slot should produce
// -----------------------------------------------------------------------------
module ws2812_bit_timer #(
   parameter int CYCLES_PER_BIT = ws2812_pkg::CYCLES_PER_BIT,
   parameter int T0H_CYCLES     = ws2812_pkg::T0H_CYCLES,
   parameter int T1H_CYCLES     = ws2812_pkg::T1H_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_run,
   input  logic i_one,
   output logic o_slot_end,
   output logic o_level
);

   // One extra bit of headroom so a high time equal to the slot still fits.
   localparam int              CW       = $clog2(CYCLES_PER_BIT + 1);
   localparam logic [CW-1:0]   LAST_CYC = CW'(CYCLES_PER_BIT - 1);
   localparam logic [CW-1:0]   T0H      = CW'(T0H_CYCLES);
   localparam logic [CW-1:0]   T1H      = CW'(T1H_CYCLES);

   logic [CW-1:0] r_cyc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cyc <= '0;
      end else if (!i_run || (r_cyc == LAST_CYC)) begin
         r_cyc <= '0;
      end else begin
         r_cyc <= r_cyc + CW'(1);
      end
   end

   assign o_slot_end = i_run && (r_cyc == LAST_CYC);
   assign o_level    = (r_cyc < (i_one ? T1H : T0H));

endmodule

// File: rtl/ws2812_pixel_serializer.sv
// -----------------------------------------------------------------------------
// ws2812_pixel_serializer
// Turns the controller's load/transmit strobes into the single-wire WS2812B
// waveform: 24 GRB bits per pixel, MSB first, one bit per CYCLES_PER_BIT clocks.
// Alive/dead cells map to fixed colours, optionally dimmed by BRIGHT_SHIFT.
//   clk, rst   clock, asynchronous active-high reset
//   io_bus     slave side of ws2812_pixel_serializer_if
//              (load_sreg, transmit_pixel, pixel_value in;
//               ws_out, busy, bit_index, proto_err out)
// -----------------------------------------------------------------------------
module ws2812_pixel_serializer #(
   parameter int          CYCLES_PER_BIT = ws2812_pkg::CYCLES_PER_BIT,
   parameter int          T0H_CYCLES     = ws2812_pkg::T0H_CYCLES,
   parameter int          T1H_CYCLES     = ws2812_pkg::T1H_CYCLES,
   parameter logic [23:0] ALIVE_GRB      = ws2812_pkg::ALIVE_GRB_DEFAULT,
   parameter logic [23:0] DEAD_GRB       = ws2812_pkg::DEAD_GRB_DEFAULT,
   parameter int          BRIGHT_SHIFT   = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   ws2812_pixel_serializer_if.slave        io_bus
);
   import ws2812_pkg::*;

   localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(BITS_PER_PIXEL - 1);

   state_t               r_state;
   logic [23:0]          r_sreg;
   logic [BIT_IDX_W-1:0] r_bit_idx;
   logic                 r_ws_out;
   logic                 r_busy;
   logic                 r_proto_err;

   logic                 w_run;
   logic                 w_slot_end;
   logic                 w_level;
   logic [23:0]          w_colour;

   assign w_run    = (r_state == SEND);
   assign w_colour = scale_grb(io_bus.pixel_value ? ALIVE_GRB : DEAD_GRB, BRIGHT_SHIFT);

   ws2812_bit_timer #(
      .CYCLES_PER_BIT (CYCLES_PER_BIT),
      .T0H_CYCLES     (T0H_CYCLES),
      .T1H_CYCLES     (T1H_CYCLES)
   ) u_bit_timer (
      .clk        (clk),
      .rst        (rst),
      .i_run      (w_run),
      .i_one      (r_sreg[23]),
      .o_slot_end (w_slot_end),
      .o_level    (w_level)
   );

   // ws_out is the registered copy of the timer level, so the line trails the
   // SEND state by one clock and the pixel occupies exactly 24 slots on the wire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_sreg      <= '0;
         r_bit_idx   <= '0;
         r_ws_out    <= 1'b0;
         r_busy      <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ws_out <= 1'b0;
               if (io_bus.load_sreg) begin
                  r_sreg  <= w_colour;
                  r_state <= LOADED;
               end else if (io_bus.transmit_pixel) begin
                  // Transmit with nothing loaded: refuse to send.
                  r_proto_err <= 1'b1;
               end
            end

            LOADED: begin
               r_ws_out <= 1'b0;
               if (io_bus.load_sreg) begin
                  r_sreg <= w_colour;
               end
               if (io_bus.transmit_pixel) begin
                  r_state   <= SEND;
                  r_busy    <= 1'b1;
                  r_bit_idx <= '0;
               end
            end

            SEND: begin
               if (io_bus.load_sreg) begin
                  // The pixel in flight is never disturbed.
                  r_proto_err <= 1'b1;
               end
               // The final slot end wins over a falling transmit_pixel: the
               // controller drops it on exactly that cycle.
               if (w_slot_end && (r_bit_idx == LAST_BIT)) begin
                  r_ws_out  <= w_level;
                  r_state   <= DONE;
                  r_busy    <= 1'b0;
                  r_bit_idx <= '0;
               end else if (!io_bus.transmit_pixel) begin
                  r_ws_out    <= 1'b0;
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
                  r_bit_idx   <= '0;
                  r_proto_err <= 1'b1;
               end else begin
                  r_ws_out <= w_level;
                  if (w_slot_end) begin
                     r_sreg    <= {r_sreg[22:0], 1'b0};
                     r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
                  end
               end
            end

            DONE: begin
               r_ws_out <= 1'b0;
               // A lingering transmit_pixel is the controller's inclusive count;
               // wait it out. A new load already queues the next pixel.
               if (io_bus.load_sreg) begin
                  r_sreg  <= w_colour;
                  r_state <= LOADED;
               end else if (!io_bus.transmit_pixel) begin
                  r_state <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign io_bus.ws_out    = r_ws_out;
   assign io_bus.busy      = r_busy;
   assign io_bus.bit_index = r_bit_idx;
   assign io_bus.proto_err = r_proto_err;

endmodule
